// File: rtl/uart_arb_pkg.sv
// Shared types for the UART transmit arbiter: FSM state encoding and default byte width.
package uart_arb_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    WRITE = 2'd2
  } state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit scanning upward from last+1
// with wrap-around, so the most recently served index always has lowest priority.
module rr_pick #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  int j;

  always_comb begin
    grant = '0;
    idx   = last;
    any   = 1'b0;
    j     = 0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(last) + k) % N;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX FIFO write port between N_REQ byte producers.
// Optional packet lock (requester keeps the grant until req_last) via UART_TX_ARB_PACKET_LOCK_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  localparam int GW        = $clog2(N_REQ)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [N_REQ-1:0]            req_last,
  output logic [N_REQ-1:0]            req_ready,
  input  logic                        tx_full,
  output logic                        wr_uart,
  output logic [DATA_WIDTH-1:0]       w_data,
  output logic [GW-1:0]               grant_id,
  output logic                        busy,
  output state_t                      state
);

  // Handshake: a byte moves from requester i when req_valid[i] & req_ready[i] on a rising edge;
  // req_ready is one-hot and only ever raised in IDLE, so at most one byte is in flight.

  state_t                  state_next;
  logic [N_REQ-1:0]        cand;
  logic [N_REQ-1:0]        win;
  logic [GW-1:0]           win_idx;
  logic                    any;
  logic                    accept;
  logic                    issue;
  logic [DATA_WIDTH-1:0]   b_reg;

`ifdef UART_TX_ARB_PACKET_LOCK_EN
  logic locked;

  // While locked, only the requester that owns the open packet is eligible.
  assign cand = locked ? (req_valid & (N_REQ'(1) << grant_id)) : req_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      locked <= 1'b0;
    end else if (accept) begin
      locked <= ~req_last[win_idx];
    end
  end
`else
  logic unused_last;

  assign cand        = req_valid;
  assign unused_last = ^req_last;
`endif

  rr_pick #(.N(N_REQ)) u_pick (
    .req   (cand),
    .last  (grant_id),
    .grant (win),
    .idx   (win_idx),
    .any   (any)
  );

  always_comb begin
    state_next = state;
    req_ready  = '0;
    accept     = 1'b0;
    issue      = 1'b0;
    unique case (state)
      IDLE: begin
        if (any) begin
          req_ready  = win;
          accept     = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (!tx_full) begin
          issue      = 1'b1;
          state_next = WRITE;
        end
      end
      WRITE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // Reset is asynchronous, so ready must also be gated combinationally.
    if (!reset_n) req_ready = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      b_reg    <= '0;
      grant_id <= GW'(N_REQ - 1);
      wr_uart  <= 1'b0;
      w_data   <= '0;
    end else begin
      state   <= state_next;
      wr_uart <= issue;
      if (accept) begin
        b_reg    <= req_data[win_idx*DATA_WIDTH +: DATA_WIDTH];
        grant_id <= win_idx;
      end
      if (issue) w_data <= b_reg;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: vector table, hand-written corner sequences, and a randomized run
// against a transaction-level reference model.
module tb_uart_tx_arbiter;
  import uart_arb_pkg::*;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           tx_full;
  logic           wr_uart;
  logic [W-1:0]   w_data;
  logic [1:0]     grant_id;
  logic           busy;
  state_t         dbg_state;

  int total = 0;
  int bad   = 0;

  uart_tx_arbiter #(.N_REQ(N), .DATA_WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_full   (tx_full),
    .wr_uart   (wr_uart),
    .w_data    (w_data),
    .grant_id  (grant_id),
    .busy      (busy),
    .state     (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #400000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n   = 1'b0;
    req_valid = '1;
    req_data  = '0;
    req_last  = '1;
    tx_full   = 1'b0;
    #1;
    chk("rst_ready", req_ready, 4'b0000);
    chk("rst_wr", wr_uart, 1'b0);
    chk("rst_wdata", w_data, 8'h00);
    chk("rst_gid", grant_id, 2'd3);
    chk("rst_busy", busy, 1'b0);
    chk("rst_state", dbg_state, IDLE);
    @(negedge clk);
    req_valid = '0;
    reset_n   = 1'b1;
  endtask

  // table-driven single transactions
  typedef struct {
    logic [N-1:0]   valid;
    logic [N*W-1:0] data;
    logic [N-1:0]   exp_ready;
    logic [W-1:0]   exp_byte;
    logic [1:0]     exp_gid;
  } vec_t;

  vec_t vecs[7];

  task automatic run_table();
    vecs[0] = '{4'b0001, 32'hD4C3B241, 4'b0001, 8'h41, 2'd0};
    vecs[1] = '{4'b1111, 32'hD4C3B2A1, 4'b0010, 8'hB2, 2'd1};
    vecs[2] = '{4'b1001, 32'hD4C3B2A1, 4'b1000, 8'hD4, 2'd3};
    vecs[3] = '{4'b0110, 32'hD4C3B2A1, 4'b0010, 8'hB2, 2'd1};
    vecs[4] = '{4'b0001, 32'hD4C3B2A1, 4'b0001, 8'hA1, 2'd0};
    vecs[5] = '{4'b1100, 32'hD4C3B2A1, 4'b0100, 8'hC3, 2'd2};
    vecs[6] = '{4'b0011, 32'hD4C3B2A1, 4'b0001, 8'hA1, 2'd0};
    for (int i = 0; i < 7; i++) begin
      req_valid = vecs[i].valid;
      req_data  = vecs[i].data;
      req_last  = '1;
      tx_full   = 1'b0;
      #1;
      chk("tbl_ready", req_ready, vecs[i].exp_ready);
      @(negedge clk);
      req_valid = '0;
      req_data  = '0;
      chk("tbl_hold_busy", busy, 1'b1);
      chk("tbl_hold_wr", wr_uart, 1'b0);
      @(negedge clk);
      chk("tbl_wr", wr_uart, 1'b1);
      chk("tbl_wdata", w_data, vecs[i].exp_byte);
      chk("tbl_gid", grant_id, vecs[i].exp_gid);
      @(negedge clk);
      chk("tbl_idle_wr", wr_uart, 1'b0);
      chk("tbl_idle_busy", busy, 1'b0);
    end
  endtask

  task automatic seq_rotation();
    logic [W-1:0] rot_exp[5];
    int n;
    rot_exp = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h10};
    n = 0;
    req_valid = 4'b1111;
    req_data  = 32'h40302010;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      if (i == 15) req_valid = '0;
      if (wr_uart) begin
        if (n < 5) begin
          chk("rot_data", w_data, rot_exp[n]);
          chk("rot_cycle", i, 2 + 3 * n);
        end
        n++;
      end
    end
    chk("rot_count", n, 5);
  endtask

  task automatic seq_full_stall();
    req_valid = 4'b0001;
    req_data  = 32'h00006655;
    tx_full   = 1'b1;
    #1;
    chk("stall_accept", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = 4'b0010;
    for (int i = 0; i < 20; i++) begin
      #1;
      chk("stall_wr", wr_uart, 1'b0);
      chk("stall_ready", req_ready, 4'b0000);
      @(negedge clk);
    end
    tx_full = 1'b0;
    #1;
    chk("stall_release_wr", wr_uart, 1'b0);
    @(negedge clk);
    #1;
    chk("stall_wr_after", wr_uart, 1'b1);
    chk("stall_wdata", w_data, 8'h55);
    chk("stall_ready_wr", req_ready, 4'b0000);
    @(negedge clk);
    #1;
    chk("stall_next_accept", req_ready, 4'b0010);
    req_valid = '0;
  endtask

  task automatic seq_drop();
    req_valid = 4'b0010;
    req_data  = 32'h33221100;
    #1;
    chk("drop_first", req_ready, 4'b0010);
    @(negedge clk);
    req_valid = 4'b1100;
    @(negedge clk);
    chk("drop_wr_r1", w_data, 8'h11);
    req_valid = 4'b1000;
    @(negedge clk);
    #1;
    chk("drop_ready", req_ready, 4'b1000);
    @(negedge clk);
    req_valid = '0;
    chk("drop_gid", grant_id, 2'd3);
    @(negedge clk);
    chk("drop_wr", wr_uart, 1'b1);
    chk("drop_wdata", w_data, 8'h33);
    @(negedge clk);
    chk("drop_idle", busy, 1'b0);
  endtask

  task automatic seq_reset_hold();
    int n;
    req_valid = 4'b0010;
    req_data  = 32'h0000AA5A;
    tx_full   = 1'b1;
    #1;
    chk("rh_accept", req_ready, 4'b0010);
    @(negedge clk);
    req_valid = 4'b1111;
    repeat (3) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rh_wr", wr_uart, 1'b0);
    chk("rh_busy", busy, 1'b0);
    chk("rh_gid", grant_id, 2'd3);
    chk("rh_ready", req_ready, 4'b0000);
    @(negedge clk);
    reset_n = 1'b1;
    tx_full = 1'b0;
    #1;
    chk("rh_first_grant", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = '0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (wr_uart) begin
        chk("rh_wdata", w_data, 8'h5A);
        n++;
      end
      @(negedge clk);
    end
    chk("rh_write_count", n, 1);
  endtask

  task automatic seq_packet();
    int k1, na;
    int order[4];
    int exp_order[4];
`ifdef UART_TX_ARB_PACKET_LOCK_EN
    exp_order = '{1, 1, 1, 0};
`else
    exp_order = '{1, 0, 1, 0};
`endif
    req_valid = 4'b0001;
    req_data  = 32'h0;
    req_last  = '1;
    @(negedge clk);
    req_valid = '0;
    repeat (2) @(negedge clk);
    k1 = 0;
    na = 0;
    order = '{-1, -1, -1, -1};
    for (int c = 0; c < 40 && na < 4; c++) begin
      req_valid = {2'b00, (k1 < 3), 1'b1};
      req_data  = {16'h0, 8'(8'hB1 + k1), 8'h0A};
      req_last  = {2'b00, (k1 == 2), 1'b1};
      #1;
      if (req_ready != '0) begin
        order[na] = req_ready[1] ? 1 : 0;
        na++;
        if (req_ready[1]) k1++;
      end
      @(negedge clk);
    end
    req_valid = '0;
    chk("pkt_accepts", na, 4);
    for (int i = 0; i < 4; i++) chk("pkt_order", order[i], exp_order[i]);
    repeat (3) @(negedge clk);
  endtask

  // scoreboard + transaction-level reference model
  logic [W-1:0] exp_q[$];
  int   m_last;
  int   m_acc;
  logic m_txf_prev;
  logic m_locked;

  task automatic rand_step(input int c);
    logic         had, wr_e;
    logic [W-1:0] b;
    logic [N-1:0] cand, er;
    int           w;
    had  = (exp_q.size() != 0);
    wr_e = had && (c >= m_acc + 2) && !m_txf_prev;
    chk("r_busy", busy, had);
    chk("r_wr", wr_uart, wr_e);
    chk("r_gid", grant_id, m_last);
    if (wr_e) begin
      b = exp_q.pop_front();
      chk("r_wdata", w_data, b);
    end
    req_valid = N'($urandom_range(0, 15));
    req_data  = $urandom;
    req_last  = N'($urandom_range(0, 15));
    tx_full   = ($urandom_range(0, 3) == 0);
    #1;
    er = '0;
    if (!had) begin
      cand = m_locked ? (req_valid & (4'b0001 << m_last)) : req_valid;
      w = -1;
      for (int k = 1; k <= N && w < 0; k++)
        if (cand[(m_last + k) % N]) w = (m_last + k) % N;
      if (w >= 0) begin
        er[w] = 1'b1;
        exp_q.push_back(req_data[w*W +: W]);
        m_last = w;
        m_acc  = c;
`ifdef UART_TX_ARB_PACKET_LOCK_EN
        m_locked = !req_last[w];
`endif
      end
    end
    chk("r_ready", req_ready, er);
    m_txf_prev = tx_full;
    @(negedge clk);
  endtask

  initial begin
    reset_n   = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '1;
    tx_full   = 1'b0;

    do_reset();
    run_table();
    do_reset();
    seq_rotation();
    do_reset();
    seq_full_stall();
    do_reset();
    seq_drop();
    do_reset();
    seq_reset_hold();
    do_reset();
    seq_packet();

    do_reset();
    exp_q.delete();
    m_last     = N - 1;
    m_acc      = -10;
    m_txf_prev = 1'b0;
    m_locked   = 1'b0;
    for (int c = 0; c < 800; c++) rand_step(c);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
